// File: rtl/ir_capture_controller_pkg.sv
// Shared types and constants for the room impulse-response capture controller.
package aurras_ir_pkg;

  typedef enum logic [2:0] {
    ST_IDLE     = 3'd0,
    ST_ARM      = 3'd1,
    ST_WAIT_IMP = 3'd2,
    ST_CAPTURE  = 3'd3,
    ST_SETTLE   = 3'd4
  } ir_state_t;

  // Accumulation rule for one read-modify-write.
  typedef enum logic [1:0] {
    PASS_FIRST = 2'd0,
    PASS_MID   = 2'd1,
    PASS_LAST  = 2'd2
  } ir_pass_t;

  // BRAM read latency; the write lands one cycle after read data returns.
  localparam int unsigned IR_BRAM_RD_LAT = 2;
  localparam int unsigned IR_SAMPLE_W    = 16;

  // Accumulator width: one 16-bit sample plus headroom for num_avg sums.
  function automatic int unsigned ir_acc_width(input int unsigned num_avg);
    return IR_SAMPLE_W + $clog2(num_avg);
  endfunction

endpackage

// File: rtl/ir_capture_controller_accum_lane.sv
// Read-modify-write pipeline: holds a captured sample until its BRAM word
// returns, then produces the accumulated (or averaged) write.
module ir_accum_lane
  import aurras_ir_pkg::*;
#(
  parameter int unsigned AW    = 10,
  parameter int unsigned ACC_W = 19,
  parameter int unsigned SHIFT = 3
) (
  input  logic                          i_clk,
  input  logic                          i_rst,
  input  logic                          i_flush,
  input  logic                          i_step,
  input  logic signed [IR_SAMPLE_W-1:0] i_sample,
  input  logic [AW-1:0]                 i_addr,
  input  logic [1:0]                    i_mode,
  input  logic signed [ACC_W-1:0]       i_rdata,
  output logic [AW-1:0]                 o_waddr,
  output logic signed [ACC_W-1:0]       o_wdata,
  output logic                          o_we,
  output logic                          o_busy
);

  localparam int unsigned D = IR_BRAM_RD_LAT;

  logic [D-1:0]                  r_vld;
  logic signed [IR_SAMPLE_W-1:0] r_smp  [D];
  logic [AW-1:0]                 r_addr [D];
  logic [1:0]                    r_mode [D];

  logic                    w_accept;
  logic signed [ACC_W-1:0] w_sample_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_result;

  // A strobe arriving while a transaction is still in flight is dropped.
  assign o_busy   = (|r_vld) | o_we;
  assign w_accept = i_step & ~o_busy & ~i_flush;

  // Delay line aligning sample, address and pass mode with the read data.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_vld <= '0;
      for (int unsigned k = 0; k < D; k++) begin
        r_smp[k]  <= '0;
        r_addr[k] <= '0;
        r_mode[k] <= '0;
      end
    end else if (i_flush) begin
      r_vld <= '0;
    end else begin
      r_vld[0]  <= w_accept;
      if (w_accept) begin
        r_smp[0]  <= i_sample;
        r_addr[0] <= i_addr;
        r_mode[0] <= i_mode;
      end
      for (int unsigned k = 1; k < D; k++) begin
        r_vld[k]  <= r_vld[k-1];
        r_smp[k]  <= r_smp[k-1];
        r_addr[k] <= r_addr[k-1];
        r_mode[k] <= r_mode[k-1];
      end
    end
  end

  // Combine returned word with the sample according to the pass.
  always_comb begin
    w_sample_ext = ACC_W'(r_smp[D-1]);
    w_sum        = i_rdata + w_sample_ext;
    w_result     = w_sum;
    case (r_mode[D-1])
      PASS_FIRST: w_result = w_sample_ext;
      PASS_LAST:  w_result = w_sum >>> SHIFT;
      default:    w_result = w_sum;
    endcase
  end

  // Registered BRAM write port.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_we    <= 1'b0;
      o_waddr <= '0;
      o_wdata <= '0;
    end else if (i_flush) begin
      o_we <= 1'b0;
    end else begin
      o_we <= r_vld[D-1];
      if (r_vld[D-1]) begin
        o_waddr <= r_addr[D-1];
        o_wdata <= w_result;
      end
    end
  end

endmodule

// File: rtl/ir_capture_controller.sv
// Sequences repeated impulse firings, captures the microphone response each
// time and averages the repetitions into an external dual-port BRAM.
module ir_capture_controller
  import aurras_ir_pkg::*;
#(
  parameter int unsigned CAPTURE_LEN   = 1024,
  parameter int unsigned NUM_AVG       = 8,
  parameter int unsigned SETTLE_STEPS  = 4800,
  parameter int unsigned TIMEOUT_STEPS = 4
) (
  input  logic                                     clk_in,
  input  logic                                     rst_in,
  input  logic                                     step_in,
  input  logic                                     start_in,
  input  logic                                     abort_in,
  input  logic signed [15:0]                       mic_in,
  output logic                                     impulse_trig_out,
  input  logic                                     impulse_active_in,
  output logic [$clog2(CAPTURE_LEN)-1:0]           acc_raddr_out,
  input  logic signed [ir_acc_width(NUM_AVG)-1:0]  acc_rdata_in,
  output logic [$clog2(CAPTURE_LEN)-1:0]           acc_waddr_out,
  output logic signed [ir_acc_width(NUM_AVG)-1:0]  acc_wdata_out,
  output logic                                     acc_we_out,
  output logic                                     busy_out,
  output logic [7:0]                               rep_out,
  output logic                                     done_out,
  output logic                                     error_out
);

  localparam int unsigned AW    = $clog2(CAPTURE_LEN);
  localparam int unsigned ACC_W = ir_acc_width(NUM_AVG);
  localparam int unsigned SHIFT = $clog2(NUM_AVG);
  localparam int unsigned SW    = $clog2(SETTLE_STEPS + 1);
  localparam int unsigned TW    = $clog2(TIMEOUT_STEPS + 1);

  localparam logic [SW-1:0] SETTLE_LAST  = SW'(SETTLE_STEPS - 1);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_STEPS - 1);
  localparam logic [7:0]    REP_LAST     = 8'(NUM_AVG - 1);

  ir_state_t     r_state;
  ir_state_t     w_next_state;
  logic [AW-1:0] r_idx;
  logic [7:0]    r_rep;
  logic [SW-1:0] r_settle_cnt;
  logic [TW-1:0] r_tmo_cnt;
  logic          r_active_d;
  logic          r_done;
  logic          r_error;

  logic          w_trig;
  logic          w_done_set;
  logic          w_error_set;
  logic          w_last_write;
  logic          w_last_rep;
  logic          w_start;
  logic          w_lane_step;
  logic          w_lane_busy;
  ir_pass_t      w_mode;

  assign w_last_rep   = (r_rep == REP_LAST);
  assign w_last_write = acc_we_out & (acc_waddr_out == '1);
  assign w_start      = (r_state == ST_IDLE) & start_in & ~abort_in;
  assign w_lane_step  = (r_state == ST_CAPTURE) & step_in;

  // Pass rule; a single-repetition measurement only ever uses PASS_FIRST.
  always_comb begin
    w_mode = PASS_MID;
    if (r_rep == 8'd0) begin
      w_mode = PASS_FIRST;
    end else if (w_last_rep) begin
      w_mode = PASS_LAST;
    end
  end

  // State register.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state and pulse decode; abort overrides everything.
  // The trigger waits on the registered generator flag, so a draining impulse
  // releases the trigger one cycle after the flag falls.
  always_comb begin
    w_next_state = r_state;
    w_trig       = 1'b0;
    w_done_set   = 1'b0;
    w_error_set  = 1'b0;
    if (abort_in) begin
      w_next_state = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_in) begin
            w_next_state = ST_ARM;
          end
        end
        ST_ARM: begin
          if (!r_active_d) begin
            w_trig       = 1'b1;
            w_next_state = ST_WAIT_IMP;
          end
        end
        ST_WAIT_IMP: begin
          if (impulse_active_in) begin
            w_next_state = ST_CAPTURE;
          end else if (step_in && (r_tmo_cnt == TIMEOUT_LAST)) begin
            w_error_set  = 1'b1;
            w_next_state = ST_IDLE;
          end
        end
        ST_CAPTURE: begin
          if (w_last_write) begin
            if (w_last_rep) begin
              w_done_set   = 1'b1;
              w_next_state = ST_IDLE;
            end else begin
              w_next_state = ST_SETTLE;
            end
          end
        end
        ST_SETTLE: begin
          if (step_in && (r_settle_cnt == SETTLE_LAST)) begin
            w_next_state = ST_ARM;
          end
        end
        default: w_next_state = ST_IDLE;
      endcase
    end
  end

  // Sample index, repetition, timeout and settle counters plus status pulses.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      r_idx        <= '0;
      r_rep        <= '0;
      r_settle_cnt <= '0;
      r_tmo_cnt    <= '0;
      r_active_d   <= 1'b0;
      r_done       <= 1'b0;
      r_error      <= 1'b0;
    end else begin
      r_active_d <= impulse_active_in;
      r_done     <= w_done_set;
      r_error    <= w_error_set;

      if (w_start) begin
        r_rep <= '0;
        r_idx <= '0;
      end else if ((r_state == ST_CAPTURE) && acc_we_out && !abort_in) begin
        r_idx <= r_idx + 1'b1;
        if (w_last_write && !w_last_rep) begin
          r_rep <= r_rep + 8'd1;
        end
      end

      if (w_trig) begin
        r_tmo_cnt <= '0;
      end else if ((r_state == ST_WAIT_IMP) && step_in && !impulse_active_in) begin
        r_tmo_cnt <= r_tmo_cnt + 1'b1;
      end

      if (r_state != ST_SETTLE) begin
        r_settle_cnt <= '0;
      end else if (step_in) begin
        r_settle_cnt <= r_settle_cnt + 1'b1;
      end
    end
  end

  ir_accum_lane #(
    .AW    (AW),
    .ACC_W (ACC_W),
    .SHIFT (SHIFT)
  ) u_lane (
    .i_clk    (clk_in),
    .i_rst    (rst_in),
    .i_flush  (abort_in),
    .i_step   (w_lane_step),
    .i_sample (mic_in),
    .i_addr   (r_idx),
    .i_mode   (w_mode),
    .i_rdata  (acc_rdata_in),
    .o_waddr  (acc_waddr_out),
    .o_wdata  (acc_wdata_out),
    .o_we     (acc_we_out),
    .o_busy   (w_lane_busy)
  );

  assign impulse_trig_out = w_trig;
  assign acc_raddr_out    = r_idx;
  assign busy_out         = (r_state != ST_IDLE);
  assign rep_out          = r_rep;
  assign done_out         = r_done;
  assign error_out        = r_error;

  // The lane's busy flag only gates strobes internally.
  logic w_unused;
  assign w_unused = w_lane_busy;

endmodule

// File: tb/tb_ir_capture_controller.sv
// Directed bench for ir_capture_controller with a small BRAM and generator model.
module tb_ir_capture_controller;

  localparam int unsigned CL    = 4;
  localparam int unsigned NA    = 2;
  localparam int unsigned SS    = 2;
  localparam int unsigned TS    = 4;
  localparam int unsigned AW    = 2;
  localparam int unsigned ACC_W = 17;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic step = 1'b0;
  logic start = 1'b0;
  logic abort = 1'b0;
  logic signed [15:0] mic = '0;
  logic trig;
  logic active;
  logic [AW-1:0] raddr;
  logic [AW-1:0] waddr;
  logic [ACC_W-1:0] rdata;
  logic [ACC_W-1:0] wdata;
  logic we;
  logic busy;
  logic [7:0] rep;
  logic done;
  logic err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ir_capture_controller #(
    .CAPTURE_LEN   (CL),
    .NUM_AVG       (NA),
    .SETTLE_STEPS  (SS),
    .TIMEOUT_STEPS (TS)
  ) dut (
    .clk_in            (clk),
    .rst_in            (rst),
    .step_in           (step),
    .start_in          (start),
    .abort_in          (abort),
    .mic_in            (mic),
    .impulse_trig_out  (trig),
    .impulse_active_in (active),
    .acc_raddr_out     (raddr),
    .acc_rdata_in      (rdata),
    .acc_waddr_out     (waddr),
    .acc_wdata_out     (wdata),
    .acc_we_out        (we),
    .busy_out          (busy),
    .rep_out           (rep),
    .done_out          (done),
    .error_out         (err)
  );

  // BRAM model: two-cycle read latency, synchronous write, bench preset.
  logic [ACC_W-1:0] mem [CL];
  logic [ACC_W-1:0] rd1 = '0;
  logic [ACC_W-1:0] rd2 = '0;
  logic preset_req = 1'b0;
  logic [ACC_W-1:0] preset_val = '0;
  always @(posedge clk) begin
    rd1 <= mem[raddr];
    rd2 <= rd1;
    if (preset_req) begin
      for (int i = 0; i < CL; i++) mem[i] <= preset_val;
    end else if (we) begin
      mem[waddr] <= wdata;
    end
  end
  assign rdata = rd2;

  // Generator model: active for three cycles after a trigger.
  logic gen_en = 1'b1;
  logic gen_force = 1'b0;
  int gen_left = 0;
  always @(posedge clk) begin
    if (gen_en && trig) gen_left <= 3;
    else if (gen_left != 0) gen_left <= gen_left - 1;
  end
  assign active = gen_force || (gen_left != 0);

  // Event monitors sampled mid-cycle.
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;
  int trig_n = 0, done_n = 0, err_n = 0, wr_n = 0;
  int done_cyc = 0, last_wr_cyc = 0;
  logic busy_at_done = 1'b1;
  logic [AW-1:0] wr_a [64];
  logic [ACC_W-1:0] wr_d [64];
  always @(negedge clk) begin
    if (trig) trig_n++;
    if (done) begin done_n++; done_cyc = cyc; busy_at_done = busy; end
    if (err) err_n++;
    if (we) begin
      if (wr_n < 64) begin wr_a[wr_n] = waddr; wr_d[wr_n] = wdata; end
      wr_n++;
      last_wr_cyc = cyc;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- stimulus helpers ----------------
  task automatic preset(input logic [ACC_W-1:0] v);
    @(posedge clk); #1 preset_val = v; preset_req = 1'b1;
    @(posedge clk); #1 preset_req = 1'b0;
  endtask

  task automatic pulse_start();
    @(posedge clk); #1 start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
  endtask

  task automatic pulse_abort();
    @(posedge clk); #1 abort = 1'b1;
    @(posedge clk); #1 abort = 1'b0;
  endtask

  task automatic strobe(input logic signed [15:0] v);
    @(posedge clk); #1 step = 1'b1; mic = v;
    @(posedge clk); #1 step = 1'b0;
    repeat (4) @(posedge clk);
  endtask

  task automatic wait_trig(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100 && !ok; i++) begin
      @(negedge clk); #1;
      if (trig_n > base) ok = 1'b1;
    end
  endtask

  task automatic wait_done(input int base, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 200 && !ok; i++) begin
      @(negedge clk); #1;
      if (done_n > base) ok = 1'b1;
    end
  endtask

  task automatic run_pass(input logic signed [15:0] v);
    repeat (6) @(posedge clk);
    for (int i = 0; i < CL; i++) strobe(v);
  endtask

  task automatic run_measure(input logic signed [15:0] v0, input logic signed [15:0] v1,
                             output bit ok);
    bit ok1, ok2, ok3;
    int tb0, db0;
    tb0 = trig_n; db0 = done_n;
    pulse_start();
    wait_trig(tb0, ok1);
    run_pass(v0);
    for (int i = 0; i < SS; i++) strobe(16'sd0);
    wait_trig(tb0 + 1, ok2);
    run_pass(v1);
    wait_done(db0, ok3);
    ok = ok1 & ok2 & ok3;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #1 rst = 1'b1;
    #2;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %0d exp 0", busy); end
    checks++; if (rep !== 8'd0) begin errors++; $display("FAIL reset_rep got %0d exp 0", rep); end
    checks++; if (we !== 1'b0 || trig !== 1'b0 || done !== 1'b0 || err !== 1'b0) begin
      errors++; $display("FAIL reset_strobes got we=%0d trig=%0d done=%0d err=%0d exp 0", we, trig, done, err);
    end
    checks++; if (raddr !== '0 || waddr !== '0 || wdata !== '0) begin
      errors++; $display("FAIL reset_bus got ra=%0h wa=%0h wd=%0h exp 0", raddr, waddr, wdata);
    end
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_idle got %0d exp 0", busy); end
  endtask

  task automatic test_basic();
    int tb0, wb0, db0;
    bit ok;
    logic [ACC_W-1:0] e;
    tb0 = trig_n; wb0 = wr_n; db0 = done_n;
    preset(17'h0AAAA);
    run_measure(16'sd100, 16'sd100, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_progress got timeout exp trig+done"); end
    checks++; if (trig_n - tb0 != 2) begin errors++; $display("FAIL basic_trigs got %0d exp 2", trig_n - tb0); end
    checks++; if (wr_n - wb0 != 8) begin errors++; $display("FAIL basic_writes got %0d exp 8", wr_n - wb0); end
    for (int i = 0; i < 8; i++) begin
      e = 17'd100;
      checks++;
      if (wr_a[wb0+i] !== 2'(i) || wr_d[wb0+i] !== e) begin
        errors++; $display("FAIL basic_wr%0d got a=%0d d=%0h exp a=%0d d=%0h", i, wr_a[wb0+i], wr_d[wb0+i], i % 4, e);
      end
    end
    checks++; if (done_n - db0 != 1) begin errors++; $display("FAIL basic_done_len got %0d exp 1", done_n - db0); end
    checks++; if (done_cyc != last_wr_cyc + 1) begin
      errors++; $display("FAIL basic_done_time got %0d exp %0d", done_cyc, last_wr_cyc + 1);
    end
    checks++; if (busy_at_done !== 1'b0) begin errors++; $display("FAIL basic_busy_fall got %0d exp 0", busy_at_done); end
    for (int i = 0; i < CL; i++) begin
      checks++; if (mem[i] !== 17'd100) begin errors++; $display("FAIL basic_mem%0d got %0h exp 64", i, mem[i]); end
    end
  endtask

  task automatic test_negative();
    int wb0;
    bit ok;
    logic [ACC_W-1:0] e;
    wb0 = wr_n;
    preset(17'h00155);
    run_measure(-16'sd3, -16'sd4, ok);
    checks++; if (!ok) begin errors++; $display("FAIL neg_progress got timeout exp trig+done"); end
    checks++; if (wr_n - wb0 != 8) begin errors++; $display("FAIL neg_writes got %0d exp 8", wr_n - wb0); end
    for (int i = 0; i < 8; i++) begin
      e = (i < 4) ? 17'h1FFFD : 17'h1FFFC;
      checks++;
      if (wr_d[wb0+i] !== e) begin
        errors++; $display("FAIL neg_wr%0d got %0h exp %0h", i, wr_d[wb0+i], e);
      end
    end
    for (int i = 0; i < CL; i++) begin
      checks++; if (mem[i] !== 17'h1FFFC) begin errors++; $display("FAIL neg_mem%0d got %0h exp 1fffc", i, mem[i]); end
    end
  endtask

  task automatic test_timeout();
    int tb0, wb0, eb0;
    tb0 = trig_n; wb0 = wr_n; eb0 = err_n;
    gen_en = 1'b0;
    pulse_start();
    @(negedge clk);
    checks++; if (trig !== 1'b1) begin errors++; $display("FAIL trig_latency got %0d exp 1", trig); end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL busy_rise got %0d exp 1", busy); end
    for (int i = 0; i < TS - 1; i++) strobe(16'sd0);
    checks++; if (err_n != eb0 || busy !== 1'b1) begin
      errors++; $display("FAIL tmo_early got errs=%0d busy=%0d exp errs=%0d busy=1", err_n - eb0, busy, 0);
    end
    @(posedge clk); #1 step = 1'b1;
    @(posedge clk); #1 step = 1'b0;
    @(negedge clk);
    checks++; if (err !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL tmo_pulse got err=%0d busy=%0d exp err=1 busy=0", err, busy);
    end
    repeat (4) @(posedge clk);
    checks++; if (err_n - eb0 != 1) begin errors++; $display("FAIL tmo_len got %0d exp 1", err_n - eb0); end
    checks++; if (wr_n != wb0) begin errors++; $display("FAIL tmo_nowrite got %0d exp 0", wr_n - wb0); end
    checks++; if (trig_n - tb0 != 1) begin errors++; $display("FAIL tmo_trigs got %0d exp 1", trig_n - tb0); end
    gen_en = 1'b1;
  endtask

  task automatic test_active_held();
    int tb0;
    tb0 = trig_n;
    gen_en = 1'b0;
    @(posedge clk); #1 gen_force = 1'b1;
    repeat (2) @(posedge clk);
    pulse_start();
    repeat (6) @(posedge clk);
    checks++; if (trig_n != tb0 || busy !== 1'b1) begin
      errors++; $display("FAIL held_notrig got trigs=%0d busy=%0d exp 0 busy=1", trig_n - tb0, busy);
    end
    @(posedge clk); #1 gen_force = 1'b0;
    @(negedge clk);
    checks++; if (trig !== 1'b0) begin errors++; $display("FAIL held_fall_cycle got %0d exp 0", trig); end
    @(negedge clk);
    checks++; if (trig !== 1'b1) begin errors++; $display("FAIL held_trig_after got %0d exp 1", trig); end
    pulse_abort();
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL held_abort got %0d exp 0", busy); end
    gen_en = 1'b1;
  endtask

  task automatic test_abort();
    int tb0, wb0, db0, eb0;
    bit ok;
    tb0 = trig_n; wb0 = wr_n; db0 = done_n; eb0 = err_n;
    pulse_start();
    wait_trig(tb0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL abort_trig got timeout exp trigger"); end
    repeat (6) @(posedge clk);
    strobe(16'sd11);
    strobe(16'sd22);
    @(posedge clk); #1 step = 1'b1; mic = 16'sd33; abort = 1'b1;
    @(posedge clk); #1 step = 1'b0; abort = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL abort_idle got %0d exp 0", busy); end
    repeat (10) @(posedge clk);
    checks++; if (wr_n - wb0 != 2) begin errors++; $display("FAIL abort_writes got %0d exp 2", wr_n - wb0); end
    checks++; if (done_n != db0 || err_n != eb0) begin
      errors++; $display("FAIL abort_pulses got done=%0d err=%0d exp 0 0", done_n - db0, err_n - eb0);
    end
    wb0 = wr_n;
    preset(17'h13579);
    run_measure(16'sd50, 16'sd50, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rerun_progress got timeout exp trig+done"); end
    checks++; if (wr_n - wb0 != 8) begin errors++; $display("FAIL rerun_writes got %0d exp 8", wr_n - wb0); end
    for (int i = 0; i < CL; i++) begin
      checks++; if (mem[i] !== 17'd50) begin errors++; $display("FAIL rerun_mem%0d got %0h exp 32", i, mem[i]); end
    end
  endtask

  task automatic test_start_ignored();
    int tb0, wb0;
    bit ok;
    tb0 = trig_n; wb0 = wr_n;
    pulse_start();
    wait_trig(tb0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ign_trig got timeout exp trigger"); end
    repeat (6) @(posedge clk);
    strobe(16'sd1);
    strobe(16'sd2);
    pulse_start();
    strobe(16'sd3);
    strobe(16'sd4);
    checks++; if (trig_n - tb0 != 1) begin errors++; $display("FAIL ign_trigs got %0d exp 1", trig_n - tb0); end
    checks++; if (rep !== 8'd1) begin errors++; $display("FAIL ign_rep got %0d exp 1", rep); end
    for (int i = 0; i < 4; i++) begin
      checks++; if (wr_a[wb0+i] !== 2'(i)) begin
        errors++; $display("FAIL ign_addr%0d got %0d exp %0d", i, wr_a[wb0+i], i);
      end
    end
    pulse_abort();
  endtask

  task automatic test_async_reset();
    int tb0;
    bit ok;
    tb0 = trig_n;
    pulse_start();
    wait_trig(tb0, ok);
    checks++; if (!ok) begin errors++; $display("FAIL ar_trig got timeout exp trigger"); end
    run_pass(16'sd7);
    checks++; if (rep !== 8'd1 || busy !== 1'b1) begin
      errors++; $display("FAIL ar_settle got rep=%0d busy=%0d exp 1 1", rep, busy);
    end
    @(posedge clk); #3 rst = 1'b1;
    #1;
    checks++; if (busy !== 1'b0 || rep !== 8'd0) begin
      errors++; $display("FAIL ar_state got busy=%0d rep=%0d exp 0 0", busy, rep);
    end
    checks++; if (waddr !== '0 || wdata !== '0 || raddr !== '0 || we !== 1'b0) begin
      errors++; $display("FAIL ar_bus got wa=%0h wd=%0h ra=%0h we=%0d exp 0", waddr, wdata, raddr, we);
    end
    #3 rst = 1'b0;
    @(negedge clk);
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ar_idle got %0d exp 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_negative();
    test_timeout();
    test_active_held();
    test_abort();
    test_start_ignored();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
